// File: rtl/pll_lock_supervisor.sv
// PLL lock supervisor: sequences the PLL reset, qualifies the returned lock
// for stability, releases the DDR3 reset and bounds relock retries.
//
// Ports:
//   init_clk  - free-running reference clock
//   rst       - synchronous active-high reset
//   lock      - PLL lock, asynchronous to init_clk
//   clr_fault - level, leaves FAULT and restarts the sequence
//   pll_rst   - reset request to the PLL initialiser
//   sys_rst   - active-high reset for the DDR3 domain
//   ready     - lock qualified (~sys_rst & ~fault)
//   fault     - retry budget exhausted
//   retry_cnt - failed attempts since last RUN or fault clear
//   loss_cnt  - lock losses seen in RUN, saturating
module pll_lock_supervisor #(
  parameter int RST_PULSE     = 16,
  parameter int LOCK_TIMEOUT  = 65536,
  parameter int STABLE_CYCLES = 1024,
  parameter int MAX_RETRIES   = 3
) (
  input  logic       init_clk,
  input  logic       rst,
  input  logic       lock,
  input  logic       clr_fault,
  output logic       pll_rst,
  output logic       sys_rst,
  output logic       ready,
  output logic       fault,
  output logic [3:0] retry_cnt,
  output logic [7:0] loss_cnt
);

  localparam int MAX_A =
    (RST_PULSE > LOCK_TIMEOUT) ?
    RST_PULSE : LOCK_TIMEOUT;
  localparam int MAX_C =
    (MAX_A > STABLE_CYCLES) ?
    MAX_A : STABLE_CYCLES;
  localparam int CW =
    (MAX_C > 1) ? $clog2(MAX_C) : 1;

  localparam logic [CW-1:0] RP_END =
    CW'(RST_PULSE - 1);
  localparam logic [CW-1:0] LT_END =
    CW'(LOCK_TIMEOUT - 1);
  localparam logic [CW-1:0] SC_END =
    CW'(STABLE_CYCLES - 1);
  localparam logic [3:0] MR =
    4'(MAX_RETRIES);

  localparam logic [2:0] S_RST   = 3'd0;
  localparam logic [2:0] S_WAIT  = 3'd1;
  localparam logic [2:0] S_STB   = 3'd2;
  localparam logic [2:0] S_RUN   = 3'd3;
  localparam logic [2:0] S_FAULT = 3'd4;

  logic          sync1_q, sync2_q;
  logic          lock_s;
  logic [2:0]    state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [3:0]    retry_q, retry_d;
  logic [7:0]    loss_q, loss_d;
  logic          pll_rst_q, pll_rst_d;
  logic          sys_rst_q, sys_rst_d;
  logic          ready_q, ready_d;
  logic          fault_q, fault_d;

  assign lock_s = sync2_q;

  always_comb begin
    state_d = state_q;
    retry_d = retry_q;
    loss_d  = loss_q;
    cnt_d   = cnt_q + CW'(1);
    unique case (state_q)
      S_RST: begin
        if (cnt_q == RP_END)
          state_d = S_WAIT;
      end
      S_WAIT: begin
        // lock wins over a coincident timeout
        if (lock_s) begin
          state_d = S_STB;
        end else if (cnt_q == LT_END) begin
          // retry_cnt reads MAX_RETRIES in FAULT
          retry_d = retry_q + 4'd1;
          if (retry_q + 4'd1 == MR)
            state_d = S_FAULT;
          else
            state_d = S_RST;
        end
      end
      S_STB: begin
        if (!lock_s) begin
          state_d = S_WAIT;
        end else if (cnt_q == SC_END) begin
          state_d = S_RUN;
          retry_d = '0;
        end
      end
      S_RUN: begin
        cnt_d = '0;
        if (!lock_s) begin
          state_d = S_WAIT;
          if (loss_q != 8'hff)
            loss_d = loss_q + 8'd1;
        end
      end
      S_FAULT: begin
        cnt_d = '0;
        if (clr_fault) begin
          state_d = S_RST;
          retry_d = '0;
        end
      end
      default: begin
        state_d = S_RST;
        cnt_d   = '0;
      end
    endcase
    if (state_d != state_q)
      cnt_d = '0;
  end

  // outputs are decoded from the next state so
  // they move on the same edge as the transition
  always_comb begin
    pll_rst_d = (state_d == S_RST) ||
                (state_d == S_FAULT);
    sys_rst_d = (state_d != S_RUN);
    ready_d   = (state_d == S_RUN);
    fault_d   = (state_d == S_FAULT);
  end

  always_ff @(posedge init_clk) begin
    if (rst) begin
      sync1_q   <= 1'b0;
      sync2_q   <= 1'b0;
      state_q   <= S_RST;
      cnt_q     <= '0;
      retry_q   <= '0;
      loss_q    <= '0;
      pll_rst_q <= 1'b1;
      sys_rst_q <= 1'b1;
      ready_q   <= 1'b0;
      fault_q   <= 1'b0;
    end else begin
      sync1_q   <= lock;
      sync2_q   <= sync1_q;
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      retry_q   <= retry_d;
      loss_q    <= loss_d;
      pll_rst_q <= pll_rst_d;
      sys_rst_q <= sys_rst_d;
      ready_q   <= ready_d;
      fault_q   <= fault_d;
    end
  end

  assign pll_rst   = pll_rst_q;
  assign sys_rst   = sys_rst_q;
  assign ready     = ready_q;
  assign fault     = fault_q;
  assign retry_cnt = retry_q;
  assign loss_cnt  = loss_q;

endmodule

// File: tb/tb_pll_lock_supervisor.sv
// Bench for pll_lock_supervisor: directed scenarios plus random lock
// activity, checked every cycle against a timeline model via a queue.
module tb_pll_lock_supervisor;

  localparam int RP = 4;
  localparam int LT = 32;
  localparam int SC = 8;
  localparam int MR = 2;

  localparam int PH_RST   = 0;
  localparam int PH_WAIT  = 1;
  localparam int PH_STB   = 2;
  localparam int PH_RUN   = 3;
  localparam int PH_FAULT = 4;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       lock = 1'b0;
  logic       clr_fault = 1'b0;
  logic       pll_rst, sys_rst;
  logic       ready, fault;
  logic [3:0] retry_cnt;
  logic [7:0] loss_cnt;

  int errors = 0;
  int checks = 0;

  logic [15:0] exp_q[$];
  logic [15:0] mon_e, mon_a;

  int   m_ph = PH_RST;
  int   m_el = 0;
  int   m_retry = 0;
  int   m_loss = 0;
  logic pipe[$] = '{1'b0, 1'b0};

  pll_lock_supervisor #(
    .RST_PULSE(RP),
    .LOCK_TIMEOUT(LT),
    .STABLE_CYCLES(SC),
    .MAX_RETRIES(MR)
  ) dut (
    .init_clk(clk),
    .rst(rst),
    .lock(lock),
    .clr_fault(clr_fault),
    .pll_rst(pll_rst),
    .sys_rst(sys_rst),
    .ready(ready),
    .fault(fault),
    .retry_cnt(retry_cnt),
    .loss_cnt(loss_cnt)
  );

  always #5 clk = ~clk;

  // model of one clock edge; lock reaches the FSM
  // through a two-sample delay line
  task automatic model(input logic r,
                       input logic l,
                       input logic c);
    int   nph;
    logic ls;
    if (r) begin
      m_ph = PH_RST;
      m_el = 0;
      m_retry = 0;
      m_loss = 0;
      pipe = '{1'b0, 1'b0};
    end else begin
      ls = pipe.pop_front();
      pipe.push_back(l);
      nph = m_ph;
      case (m_ph)
        PH_RST:
          if (m_el == RP - 1) nph = PH_WAIT;
        PH_WAIT:
          if (ls) nph = PH_STB;
          else if (m_el == LT - 1) begin
            m_retry++;
            nph = (m_retry == MR) ?
                  PH_FAULT : PH_RST;
          end
        PH_STB:
          if (!ls) nph = PH_WAIT;
          else if (m_el == SC - 1) begin
            nph = PH_RUN;
            m_retry = 0;
          end
        PH_RUN:
          if (!ls) begin
            nph = PH_WAIT;
            if (m_loss < 255) m_loss++;
          end
        default:
          if (c) begin
            nph = PH_RST;
            m_retry = 0;
          end
      endcase
      m_el = (nph == m_ph) ? m_el + 1 : 0;
      m_ph = nph;
    end
  endtask

  function automatic logic [15:0] exp_vec();
    logic p, s, rd, f;
    p  = (m_ph == PH_RST) ||
         (m_ph == PH_FAULT);
    s  = (m_ph != PH_RUN);
    rd = (m_ph == PH_RUN);
    f  = (m_ph == PH_FAULT);
    return {p, s, rd, f,
            4'(m_retry), 8'(m_loss)};
  endfunction

  always @(posedge clk) begin
    #1;
    if (exp_q.size() > 0) begin
      mon_e = exp_q.pop_front();
      mon_a = {pll_rst, sys_rst, ready, fault,
               retry_cnt, loss_cnt};
      checks++;
      if (mon_a !== mon_e) begin
        errors++;
        $display("FAIL outputs t=%0t got=%h exp=%h",
                 $time, mon_a, mon_e);
      end
    end
  end

  // called at posedge+2; returns at next posedge+2
  task automatic step(input logic r,
                      input logic l,
                      input logic c);
    rst = r;
    lock = l;
    clr_fault = c;
    model(r, l, c);
    exp_q.push_back(exp_vec());
    @(posedge clk);
    #2;
  endtask

  task automatic chk(input string n,
                     input int act,
                     input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s got=%0d exp=%0d",
               n, act, exp);
    end
  endtask

  task automatic run_until(input int ph,
                           input logic l,
                           input int bound);
    int n = 0;
    while (m_ph != ph && n < bound) begin
      step(1'b0, l, 1'b0);
      n++;
    end
    chk("phase_reached", m_ph, ph);
  endtask

  task automatic do_reset();
    step(1'b1, 1'b0, 1'b0);
    step(1'b1, 1'b0, 1'b0);
  endtask

  initial begin
    logic lv;
    int   n;
    @(posedge clk);
    #2;

    // nominal lock
    do_reset();
    chk("rst_pll_rst", pll_rst, 1);
    chk("rst_sys_rst", sys_rst, 1);
    chk("rst_ready", ready, 0);
    chk("rst_fault", fault, 0);
    chk("rst_retry", retry_cnt, 0);
    chk("rst_loss", loss_cnt, 0);
    repeat (RP - 1) step(1'b0, 1'b0, 1'b0);
    chk("pulse_hold", pll_rst, 1);
    step(1'b0, 1'b0, 1'b0);
    chk("pulse_end", pll_rst, 0);
    repeat (10) step(1'b0, 1'b0, 1'b0);
    repeat (2 + 1 + SC - 1) step(1'b0, 1'b1, 1'b0);
    chk("sysrst_before", sys_rst, 1);
    step(1'b0, 1'b1, 1'b0);
    chk("sysrst_fall", sys_rst, 0);
    chk("nom_ready", ready, 1);
    chk("nom_retry", retry_cnt, 0);

    // stability glitch
    do_reset();
    run_until(PH_WAIT, 1'b0, 20);
    n = 0;
    while (!(m_ph == PH_STB && m_el == 5) &&
           n < 50) begin
      step(1'b0, 1'b1, 1'b0);
      n++;
    end
    chk("glitch_at5", m_el, 5);
    step(1'b0, 1'b0, 1'b0);
    run_until(PH_WAIT, 1'b1, 5);
    chk("glitch_sysrst", sys_rst, 1);
    chk("glitch_retry", retry_cnt, 0);
    run_until(PH_STB, 1'b1, 5);
    repeat (SC - 1) step(1'b0, 1'b1, 1'b0);
    chk("glitch_notyet", ready, 0);
    step(1'b0, 1'b1, 1'b0);
    chk("glitch_ready", ready, 1);

    // single timeout then lock
    do_reset();
    run_until(PH_WAIT, 1'b0, 20);
    repeat (LT) step(1'b0, 1'b0, 1'b0);
    chk("to_retry", retry_cnt, 1);
    chk("to_repulse", pll_rst, 1);
    repeat (RP - 1) step(1'b0, 1'b0, 1'b0);
    chk("to_pulse_hold", pll_rst, 1);
    step(1'b0, 1'b0, 1'b0);
    chk("to_pulse_end", pll_rst, 0);
    run_until(PH_RUN, 1'b1, 30);
    chk("to_retry_clr", retry_cnt, 0);

    // fault and recovery
    do_reset();
    repeat (2 * LT + 2 * RP - 1)
      step(1'b0, 1'b0, 1'b0);
    chk("flt_early", fault, 0);
    step(1'b0, 1'b0, 1'b0);
    chk("flt_fault", fault, 1);
    chk("flt_retry", retry_cnt, MR);
    chk("flt_pll", pll_rst, 1);
    repeat (5) step(1'b0, 1'b0, 1'b0);
    chk("flt_hold", fault, 1);
    step(1'b0, 1'b0, 1'b1);
    chk("clr_fault", fault, 0);
    chk("clr_retry", retry_cnt, 0);
    chk("clr_pll", pll_rst, 1);
    repeat (RP - 1) step(1'b0, 1'b0, 1'b0);
    chk("clr_pulse_hold", pll_rst, 1);
    step(1'b0, 1'b0, 1'b0);
    chk("clr_pulse_end", pll_rst, 0);

    // repeated loss in RUN
    run_until(PH_RUN, 1'b1, 60);
    for (int i = 0; i < 300; i++) begin
      step(1'b0, 1'b0, 1'b0);
      step(1'b0, 1'b1, 1'b0);
      step(1'b0, 1'b1, 1'b0);
      chk("loss_sysrst", sys_rst, 1);
      chk("loss_ready", ready, 0);
      run_until(PH_RUN, 1'b1, 20);
    end
    chk("loss_sat", loss_cnt, 255);

    // reset mid-STABLE
    step(1'b0, 1'b0, 1'b0);
    run_until(PH_STB, 1'b1, 10);
    repeat (3) step(1'b0, 1'b1, 1'b0);
    step(1'b1, 1'b1, 1'b0);
    chk("mid_pll", pll_rst, 1);
    chk("mid_sys", sys_rst, 1);
    chk("mid_ready", ready, 0);
    chk("mid_fault", fault, 0);
    chk("mid_retry", retry_cnt, 0);
    chk("mid_loss", loss_cnt, 0);

    // random lock activity
    lv = 1'b0;
    for (int i = 0; i < 3000; i++) begin
      if ($urandom_range(0, 39) == 0) lv = ~lv;
      step($urandom_range(0, 999) == 0, lv,
           $urandom_range(0, 7) == 0);
    end

    @(posedge clk);
    #3;
    chk("queue_drained", exp_q.size(), 0);
    $display("Result: errors=%0d of %0d checks",
             errors, checks);
    $finish;
  end

endmodule
